// File: rtl/led_display_queue.sv
// rtl/led_display_queue.sv - UART byte to LED driver with latch, queued-dwell and blink modes
// Mode is runtime-selectable; a mode change flushes the queue and restarts timers while led holds.
module led_display_queue #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          uart_data,
  input  logic                       uart_ready,
  input  logic [1:0]                 mode,
  input  logic                       clear_ovf,
  output logic [DATA_W-1:0]          led,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam logic [1:0] MODE_QUEUE = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [0:0]        state;
  logic [DW_W-1:0]   dwell;
  logic [BL_W-1:0]   blink_cnt;
  logic              phase;
  logic [DATA_W-1:0] held;
  logic [1:0]        mode_q;

  logic              mode_chg, is_queue, is_blink, fifo_full;
  logic              pop, push, drop;
  logic [CNT_W-1:0]  count_cur, count_nxt;
  logic [PTR_W-1:0]  wr_cur, rd_cur, wr_nxt, rd_nxt;
  logic [0:0]        state_cur, state_nxt;
  logic [DW_W-1:0]   dwell_cur, dwell_nxt;
  logic [BL_W-1:0]   blink_nxt;
  logic              phase_nxt;
  logic [DATA_W-1:0] held_nxt, led_nxt;
  logic              ovf_nxt, busy_nxt;

  // On a mode change the "current" view of the queue is already flushed, so a
  // strobe in that same cycle is handled by the new mode against an empty FIFO.
  always_comb begin
    mode_chg  = (mode != mode_q);
    is_queue  = (mode == MODE_QUEUE);
    is_blink  = (mode == MODE_BLINK);
    count_cur = mode_chg ? '0 : fifo_count;
    wr_cur    = mode_chg ? '0 : wr_ptr;
    rd_cur    = mode_chg ? '0 : rd_ptr;
    state_cur = mode_chg ? ST_IDLE : state;
    dwell_cur = mode_chg ? '0 : dwell;
    fifo_full = (count_cur == FULL_COUNT);

    pop  = is_queue && (count_cur != '0) && ((state_cur == ST_IDLE) || (dwell_cur == '0));
    push = is_queue && uart_ready && (!fifo_full || pop);
    drop = is_queue && uart_ready && fifo_full && !pop;

    count_nxt = count_cur;
    if (push && !pop) begin
      count_nxt = count_cur + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count_cur - CNT_W'(1);
    end
    wr_nxt = push ? wr_cur + PTR_W'(1) : wr_cur;
    rd_nxt = pop  ? rd_cur + PTR_W'(1) : rd_cur;

    state_nxt = state_cur;
    dwell_nxt = dwell_cur;
    led_nxt   = led;
    held_nxt  = mode_chg ? led : held;
    phase_nxt = mode_chg ? 1'b1 : phase;
    blink_nxt = mode_chg ? '0 : blink_cnt;

    if (is_queue) begin
      if (pop) begin
        led_nxt   = mem[rd_cur];
        dwell_nxt = DWELL_LOAD;
        state_nxt = ST_SHOW;
      end else if (state_cur == ST_SHOW) begin
        if (dwell_cur != '0) begin
          dwell_nxt = dwell_cur - DW_W'(1);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    end else if (is_blink) begin
      if (uart_ready) begin
        held_nxt  = uart_data;
        phase_nxt = 1'b1;
        blink_nxt = '0;
        led_nxt   = uart_data;
      end else if (!mode_chg) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_nxt = '0;
          phase_nxt = ~phase;
        end else begin
          blink_nxt = blink_cnt + BL_W'(1);
        end
        led_nxt = phase_nxt ? held : '0;
      end
    end else if (uart_ready) begin
      led_nxt = uart_data;
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    ovf_nxt  = drop | (overflow & ~clear_ovf);
    busy_nxt = (state_nxt == ST_SHOW) || (count_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led        <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      state      <= ST_IDLE;
      dwell      <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
      held       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mode_q     <= mode;
    end else begin
      led        <= led_nxt;
      fifo_count <= count_nxt;
      overflow   <= ovf_nxt;
      busy       <= busy_nxt;
      state      <= state_nxt;
      dwell      <= dwell_nxt;
      blink_cnt  <= blink_nxt;
      phase      <= phase_nxt;
      held       <= held_nxt;
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      mode_q     <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_cur] <= uart_data;
    end
  end

endmodule

// File: tb/tb_led_display_queue.sv
// tb/tb_led_display_queue.sv - self-checking bench for led_display_queue
// A queue/timestamp model predicts every output each cycle; directed literals pin key points.
module tb_led_display_queue;

  localparam int DEPTH_C = 4;
  localparam int DWELL_C = 4;
  localparam int BLINK_C = 3;

  logic       clk;
  logic       reset;
  logic [7:0] uart_data;
  logic       uart_ready;
  logic [1:0] mode;
  logic       clear_ovf;
  logic [7:0] led;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;

  led_display_queue #(
    .DATA_W(8),
    .DEPTH(DEPTH_C),
    .DWELL_CYCLES(DWELL_C),
    .BLINK_CYCLES(BLINK_C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_data(uart_data),
    .uart_ready(uart_ready),
    .mode(mode),
    .clear_ovf(clear_ovf),
    .led(led),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bytes in a queue, display time tracked by the cycle a byte appeared,
  // blink phase derived from cycles elapsed since the last (re)start.
  logic [7:0] mq[$];
  logic [7:0] m_led, m_held;
  bit         m_ovf, m_busy, showing, chg, m_drop, chk_en;
  int         cyc = 0, shown_at = 0, blink_start = 0;
  logic [1:0] mode_prev;

  always @(posedge clk) begin
    cyc++;
    m_drop = 0;
    if (reset) begin
      mq.delete();
      m_led = 8'h00; m_held = 8'h00; m_ovf = 0; showing = 0;
      blink_start = cyc; mode_prev = mode;
    end else begin
      chg = (mode != mode_prev);
      mode_prev = mode;
      if (chg) begin
        mq.delete();
        showing = 0;
        m_held = m_led;
        blink_start = cyc;
      end
      if (mode == 2'b01) begin
        if (mq.size() > 0 && (!showing || cyc - shown_at >= DWELL_C)) begin
          m_led = mq.pop_front();
          showing = 1;
          shown_at = cyc;
        end else if (showing && cyc - shown_at >= DWELL_C) begin
          showing = 0;
        end
        if (uart_ready) begin
          if (mq.size() < DEPTH_C) mq.push_back(uart_data);
          else m_drop = 1;
        end
      end else if (mode == 2'b10) begin
        if (uart_ready) begin
          m_held = uart_data;
          blink_start = cyc;
        end
        m_led = (((cyc - blink_start) / BLINK_C) % 2 == 0) ? m_held : 8'h00;
      end else if (uart_ready) begin
        m_led = uart_data;
      end
      if (m_drop) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
    m_busy = showing || (mq.size() != 0);
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_led", led, m_led);
      check("cmp_count", fifo_count, mq.size());
      check("cmp_ovf", overflow, m_ovf);
      check("cmp_busy", busy, m_busy);
    end
  end

  task automatic step(input logic r, input logic [7:0] d);
    uart_ready = r;
    uart_data  = d;
    @(negedge clk);
    uart_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mode = 2'b00; uart_ready = 1'b0; uart_data = 8'h00; clear_ovf = 1'b0;
    step(1'b0, 8'h00);
    check("rst_led", led, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    step(1'b0, 8'h00);
    reset = 1'b0;

    step(1'b1, 8'hA5);
    check("latch_a5", led, 8'hA5);
    idle(10);
    check("latch_hold", led, 8'hA5);

    mode = 2'b01; idle(1);
    step(1'b1, 8'h11); check("q_lat_edge1", led, 8'hA5);
    step(1'b1, 8'h22); check("q_lat_edge2", led, 8'h11); check("q_busy", busy, 1);
    step(1'b1, 8'h33);
    idle(2); check("q_11_last", led, 8'h11);
    idle(1); check("q_22_first", led, 8'h22); check("model_22", m_led, 8'h22);
    idle(3); check("q_22_last", led, 8'h22);
    idle(1); check("q_33_first", led, 8'h33);
    idle(3); check("q_33_last", led, 8'h33); check("q_busy_last", busy, 1);
    idle(1); check("q_idle_led", led, 8'h33); check("q_idle_busy", busy, 0);
    check("model_idle_busy", m_busy, 0);

    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    check("full_count", fifo_count, 4); check("full_led", led, 8'h01);
    step(1'b1, 8'h06);
    check("fullpop_count", fifo_count, 4); check("fullpop_ovf", overflow, 0);
    check("fullpop_led", led, 8'h02);
    step(1'b1, 8'h07);
    check("drop_ovf", overflow, 1); check("drop_count", fifo_count, 4);
    check("model_drop_ovf", m_ovf, 1);
    clear_ovf = 1'b1; step(1'b0, 8'h00); clear_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    clear_ovf = 1'b1; step(1'b1, 8'h77); clear_ovf = 1'b0;
    check("clr_drop_ovf", overflow, 1);
    idle(1); check("q_03", led, 8'h03); check("q_03_count", fifo_count, 3);

    mode = 2'b00; step(1'b0, 8'h00);
    check("chg_count", fifo_count, 0); check("chg_led", led, 8'h03);
    check("chg_busy", busy, 0); check("chg_keeps_ovf", overflow, 1);

    mode = 2'b10; idle(1); check("blink_chg_led", led, 8'h03);
    step(1'b1, 8'hF0); check("blink_on0", led, 8'hF0);
    idle(2); check("blink_on2", led, 8'hF0);
    idle(1); check("blink_off0", led, 8'h00);
    idle(2); check("blink_off2", led, 8'h00);
    idle(1); check("blink_on_again", led, 8'hF0);
    idle(3); check("blink_off_again", led, 8'h00);
    step(1'b1, 8'h0F); check("blink_restart", led, 8'h0F);
    idle(2); check("blink_restart_on2", led, 8'h0F);
    idle(1); check("blink_restart_off", led, 8'h00);

    mode = 2'b01; idle(1);
    step(1'b1, 8'h5A);
    step(1'b1, 8'h6B); check("rs_show_led", led, 8'h5A); check("rs_show_busy", busy, 1);
    step(1'b1, 8'h7C);
    reset = 1'b1; step(1'b1, 8'h8D); reset = 1'b0;
    check("rst2_led", led, 8'h00); check("rst2_count", fifo_count, 0);
    check("rst2_ovf", overflow, 0); check("rst2_busy", busy, 0);
    idle(3); check("post_rst_led", led, 8'h00); check("post_rst_busy", busy, 0);
    step(1'b1, 8'h09); check("post_rst_lat1", led, 8'h00);
    idle(1); check("post_rst_lat2", led, 8'h09);

    mode = 2'b11; step(1'b1, 8'hC3);
    check("latch11_led", led, 8'hC3); check("latch11_busy", busy, 0);
    check("latch11_count", fifo_count, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
